ctrl_accum_param: RTL
=====================

Name: ctrl_accum_param

Overview:
Parametrised control FSM for the FIFO -> accumulator -> RAM datapath in the 2 MHz domain.
- Pops bytes from the FIFO, tells the accumulator when to clear, and issues one RAM write per BYTES_PER_WORD bytes to an internally generated, auto-incrementing address.
- Adds three capabilities: a configurable word length, a flush that writes out a partial word, and a selectable wrap or stop-when-full policy for the RAM address.

Parameters:
BYTES_PER_WORD, 4, bytes accumulated per RAM word; legal range >= 2.
ADDR_W, 4, RAM address width; RAM depth is 2**ADDR_W.
WRAP_EN, 1, 1 = ram_addr wraps to 0 after the last location; 0 = block halts in FULL after writing the last location.

Ports:
clk  input  1  2 MHz clock.
reset_n  input  1  asynchronous active-low reset.
empty  input  1  FIFO empty flag.
flush  input  1  single-cycle request to write the current partial word.
read  output  1  FIFO pop; each high cycle consumes one byte.
zero_sel  output  1  accumulator clear select; high = next byte starts a new word.
write_ram  output  1  one-cycle RAM write strobe.
ram_addr  output  ADDR_W  RAM write address; valid while write_ram is high.
byte_idx  output  max(1,$clog2(BYTES_PER_WORD))  index of the next byte within the word.
ram_full  output  1  sticky; high in FULL state (WRAP_EN=0 only).

Behaviour:
Clock and reset: clk, reset_n asynchronous active-low. All outputs are registered or decoded from registered state.

Reset values:
- read=0, zero_sel=1, write_ram=0, ram_addr=0, byte_idx=0, ram_full=0.
- Main FSM = RUN; flush_pend=0.

Main FSM states:
- RUN: accumulating.
- WRITE: write_ram=1 for exactly one cycle.
- FULL: terminal; left only by reset.

Read path:
- read_ns = !empty && !flush && !flush_pend && (state_ns != FULL).
- read is registered, so latency is one cycle from empty falling to read rising.
- Back-to-back reads allowed, including during WRITE.

Byte counter:
- On any cycle with read=1, byte_idx increments; at BYTES_PER_WORD-1 it wraps to 0 (word complete).
- Counting is independent of FSM state.

zero_sel: registered as (byte_idx_ns == 0).

Transitions from RUN:
- Word complete -> WRITE.
- Else if flush_pend && read=0 && byte_idx != 0 -> byte_idx <= 0, clear flush_pend, -> WRITE.
- Else if flush_pend && read=0 && byte_idx == 0 -> clear flush_pend, stay in RUN (nothing to write).
- Word complete has priority over flush; flush_pend persists and is re-evaluated on return to RUN.

flush:
- Sampled every cycle in RUN or WRITE; sets flush_pend.
- Ignored in FULL.

WRITE state:
- write_ram=1 and ram_addr holds for this cycle.
- Next edge: if ram_addr == 2**ADDR_W-1 and WRAP_EN=0 -> FULL, ram_full <= 1.
- Otherwise ram_addr increments (wraps modulo 2**ADDR_W) and the FSM returns to RUN.

FULL state:
- read=0, write_ram=0, ram_full=1.
- empty and flush are ignored.
- Any byte popped during the final WRITE cycle is discarded.

Reset mid-word: byte_idx, address and flush_pend are cleared immediately; partial data is lost.

Test Plan:
1. BYTES_PER_WORD=4, empty held 0 from reset release -> read high from cycle 1 continuously; write_ram pulses every 4 cycles starting cycle 5 at ram_addr 0,1,2...; zero_sel high on cycles where byte_idx_ns=0.
2. empty toggles 1/0 every cycle -> read every other cycle; byte_idx advances only on read cycles; write_ram fires exactly once per 4 reads.
3. Flush after 2 bytes (byte_idx=2, empty=1) -> flush_pend set, write_ram one cycle later at current ram_addr, byte_idx=0, zero_sel=1; flush with byte_idx=0 -> no write_ram.
4. Flush on the same cycle as the 4th read -> a single write_ram for the full word; no extra write for the flush.
5. WRAP_EN=1, ADDR_W=2, 5 full words -> writes at addresses 0,1,2,3,0; ram_full stays 0.
6. WRAP_EN=0, ADDR_W=2, 5 words offered -> writes at 0..3, then ram_full=1, read stuck at 0 with empty=0; reset_n pulse mid-FULL -> all outputs return to reset values.

Source files
------------

// File: rtl/ctrl_accum_param.sv
// Control FSM for the FIFO -> accumulator -> RAM path: pops bytes, steers accumulator clear,
// and writes one RAM word per BYTES_PER_WORD bytes (or on flush) to an auto-incrementing address.
module ctrl_accum_param #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          WRAP_EN        = 1'b1,
    localparam int unsigned IDX_W = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              empty,
    input  logic              flush,
    output logic              read,
    output logic              zero_sel,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              ram_full
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic              read_q, read_d;
    logic              zero_sel_q, zero_sel_d;
    logic              write_ram_q, write_ram_d;
    logic              ram_full_q, ram_full_d;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              word_done;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        flush_pend_d = flush_pend_q;
        ram_addr_d   = ram_addr_q;
        word_done    = read_q && (byte_idx_q == LAST_IDX);

        if (read_q) begin
            byte_idx_d = word_done ? '0 : byte_idx_q + 1'b1;
        end
        if (state_q != FULL && flush) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (word_done) begin
                    state_d = WRITE;
                end else if (flush_pend_q && !read_q) begin
                    // a request arriving this very cycle re-arms the pending flag
                    flush_pend_d = flush;
                    if (byte_idx_q != '0) begin
                        byte_idx_d = '0;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!WRAP_EN && ram_addr_q == '1) begin
                    state_d = FULL;
                end else begin
                    ram_addr_d = ram_addr_q + 1'b1;
                    state_d    = RUN;
                end
            end
            FULL:    state_d = FULL;
            default: state_d = RUN;
        endcase

        read_d      = !empty && !flush && !flush_pend_q && (state_d != FULL);
        zero_sel_d  = (byte_idx_d == '0);
        write_ram_d = (state_d == WRITE);
        ram_full_d  = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            read_q       <= 1'b0;
            zero_sel_q   <= 1'b1;
            write_ram_q  <= 1'b0;
            ram_full_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            ram_addr_q   <= '0;
            byte_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            zero_sel_q   <= zero_sel_d;
            write_ram_q  <= write_ram_d;
            ram_full_q   <= ram_full_d;
            flush_pend_q <= flush_pend_d;
            ram_addr_q   <= ram_addr_d;
            byte_idx_q   <= byte_idx_d;
        end
    end

    assign read      = read_q;
    assign zero_sel  = zero_sel_q;
    assign write_ram = write_ram_q;
    assign ram_full  = ram_full_q;
    assign ram_addr  = ram_addr_q;
    assign byte_idx  = byte_idx_q;

endmodule
